// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction word store for the core's fetch port.
// A byte-stream loader (valid/ready) assembles big-endian 32-bit words into a
// word RAM; once a load completes the block enters RUN and serves fetches
// combinationally. Outside RUN every fetch returns 32'h0 (MIPS NOP).
// Optional build macro INST_ROM_ALIGN_CHK_EN adds a pc_misalign output and
// suppresses misaligned fetches.
`timescale 1ns/1ps

module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [31:0]       pc,
    input  logic              pc_vld,
    output logic [31:0]       inst,
    input  logic              ld_start,
    input  logic [7:0]        ld_byte,
    input  logic              ld_vld,
    input  logic              ld_last,
    output logic              ld_rdy,
    output logic              ld_done,
    output logic              ld_ovf,
    output logic [ADDR_W:0]   ld_words
`ifdef INST_ROM_ALIGN_CHK_EN
    ,
    output logic              pc_misalign
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    // Handshake: a byte moves when ld_vld && ld_rdy at a rising clk edge.
    // ld_rdy is high for the whole LOAD state, including when memory is full
    // (bytes are then dropped and ld_ovf is raised), so the source never stalls.
    // A coincident ld_start wins and the byte offered in that cycle is discarded.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_reg;
    logic [31:0] asm_next;
    logic        accept;
    logic        full;
    logic        word_wr;
    logic        serve;
    logic [31:0] mem [DEPTH];

    // ld_words doubles as the write pointer; its top bit marks a full memory.
    assign full = ld_words[ADDR_W];

    // Next-state logic, handshake and byte-merge of the incoming byte.
    always_comb begin
        state_next = state;
        ld_rdy     = 1'b0;
        accept     = 1'b0;
        word_wr    = 1'b0;
        asm_next   = asm_reg;
        ld_rdy     = (state == LOAD);
        accept     = (state == LOAD) && ld_vld && !ld_start;
        case (byte_cnt)
            2'd0:    asm_next[31:24] = ld_byte;
            2'd1:    asm_next[23:16] = ld_byte;
            2'd2:    asm_next[15:8]  = ld_byte;
            default: asm_next[7:0]   = ld_byte;
        endcase
        // Low bytes of a partial final word are still zero in asm_reg.
        word_wr = accept && !full && ((byte_cnt == 2'd3) || ld_last);
        if (ld_start) begin
            state_next = LOAD;
        end else if (accept && ld_last) begin
            state_next = RUN;
        end
    end

    // State register; reset drops straight to IDLE so fetches gate off at once.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Loader datapath: byte count, assembly word, word count, status flags.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            byte_cnt <= 2'd0;
            asm_reg  <= 32'h0;
            ld_words <= '0;
            ld_ovf   <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            ld_done <= accept && ld_last;
            if (ld_start) begin
                byte_cnt <= 2'd0;
                asm_reg  <= 32'h0;
                ld_words <= '0;
                ld_ovf   <= 1'b0;
            end else if (accept) begin
                if (full) begin
                    ld_ovf <= 1'b1;
                end else if (word_wr) begin
                    ld_words <= ld_words + {{ADDR_W{1'b0}}, 1'b1};
                    byte_cnt <= 2'd0;
                    asm_reg  <= 32'h0;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                    asm_reg  <= asm_next;
                end
            end
        end
    end

    // Word RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[ld_words[ADDR_W-1:0]] <= asm_next;
        end
    end

    assign serve = (state == RUN) && pc_vld && (pc[31:ADDR_W+2] == '0);

`ifdef INST_ROM_ALIGN_CHK_EN
    // Fetch port: misaligned fetches in RUN are flagged and return NOP.
    always_comb begin
        pc_misalign = (state == RUN) && pc_vld && (pc[1:0] != 2'b00);
        inst        = 32'h0;
        if (serve && !pc_misalign) begin
            inst = mem[pc[ADDR_W+1:2]];
        end
    end
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc[1:0];

    // Fetch port: byte offset ignored, misaligned pc reads the containing word.
    always_comb begin
        inst = 32'h0;
        if (serve) begin
            inst = mem[pc[ADDR_W+1:2]];
        end
    end
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: a large (ADDR_W=10) and a tiny (ADDR_W=2)
// instance share all stimulus. Drivers push expected responses into queues;
// a negedge monitor pops and compares on every probe strobe and ld_done pulse.
`timescale 1ns/1ps

module tb_inst_rom_loader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_;
    logic [31:0] pc;
    logic        pc_vld;
    logic        ld_start;
    logic [7:0]  ld_byte;
    logic        ld_vld;
    logic        ld_last;

    logic [31:0] a_inst, b_inst;
    logic        a_rdy, b_rdy, a_done, b_done, a_ovf, b_ovf;
    logic [10:0] a_words;
    logic [2:0]  b_words;
`ifdef INST_ROM_ALIGN_CHK_EN
    logic        a_mis, b_mis;
    localparam logic ALIGN_CHK = 1'b1;
`else
    localparam logic ALIGN_CHK = 1'b0;
`endif

    inst_rom_loader #(.ADDR_W(10)) u_big (
        .clk(clk), .rst_(rst_), .pc(pc), .pc_vld(pc_vld), .inst(a_inst),
        .ld_start(ld_start), .ld_byte(ld_byte), .ld_vld(ld_vld), .ld_last(ld_last),
        .ld_rdy(a_rdy), .ld_done(a_done), .ld_ovf(a_ovf), .ld_words(a_words)
`ifdef INST_ROM_ALIGN_CHK_EN
        , .pc_misalign(a_mis)
`endif
    );

    inst_rom_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst_(rst_), .pc(pc), .pc_vld(pc_vld), .inst(b_inst),
        .ld_start(ld_start), .ld_byte(ld_byte), .ld_vld(ld_vld), .ld_last(ld_last),
        .ld_rdy(b_rdy), .ld_done(b_done), .ld_ovf(b_ovf), .ld_words(b_words)
`ifdef INST_ROM_ALIGN_CHK_EN
        , .pc_misalign(b_mis)
`endif
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] inst;
        logic        rdy;
        logic [10:0] words;
        logic        ovf;
        logic        mis;
    } probe_t;

    probe_t      exp_qa[$];
    probe_t      exp_qb[$];
    logic [11:0] exp_done_qa[$];   // {ovf, words}
    logic [11:0] exp_done_qb[$];
    logic        stb_a = 1'b0;
    logic        stb_b = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic probe_t mk(input logic [31:0] i, input logic r,
                                  input logic [10:0] w, input logic o, input logic m);
        probe_t p;
        p.inst = i; p.rdy = r; p.words = w; p.ovf = o; p.mis = m;
        return p;
    endfunction

    // Monitor: compare on probe strobes and on every ld_done pulse.
    always @(negedge clk) begin
        probe_t      e;
        logic [11:0] d;
        if (stb_a) begin
            if (exp_qa.size() == 0) begin
                chk("a_probe_queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_qa.pop_front();
                chk("a_inst", a_inst, e.inst);
                chk("a_ld_rdy", {31'b0, a_rdy}, {31'b0, e.rdy});
                chk("a_ld_words", {21'b0, a_words}, {21'b0, e.words});
                chk("a_ld_ovf", {31'b0, a_ovf}, {31'b0, e.ovf});
`ifdef INST_ROM_ALIGN_CHK_EN
                chk("a_pc_misalign", {31'b0, a_mis}, {31'b0, e.mis});
`endif
            end
        end
        if (stb_b) begin
            if (exp_qb.size() == 0) begin
                chk("b_probe_queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_qb.pop_front();
                chk("b_inst", b_inst, e.inst);
                chk("b_ld_rdy", {31'b0, b_rdy}, {31'b0, e.rdy});
                chk("b_ld_words", {29'b0, b_words}, {21'b0, e.words});
                chk("b_ld_ovf", {31'b0, b_ovf}, {31'b0, e.ovf});
`ifdef INST_ROM_ALIGN_CHK_EN
                chk("b_pc_misalign", {31'b0, b_mis}, {31'b0, e.mis});
`endif
            end
        end
        if (a_done) begin
            if (exp_done_qa.size() == 0) begin
                chk("a_unexpected_ld_done", 32'd1, 32'd0);
            end else begin
                d = exp_done_qa.pop_front();
                chk("a_done_words", {21'b0, a_words}, {21'b0, d[10:0]});
                chk("a_done_ovf", {31'b0, a_ovf}, {31'b0, d[11]});
            end
        end
        if (b_done) begin
            if (exp_done_qb.size() == 0) begin
                chk("b_unexpected_ld_done", 32'd1, 32'd0);
            end else begin
                d = exp_done_qb.pop_front();
                chk("b_done_words", {29'b0, b_words}, {21'b0, d[10:0]});
                chk("b_done_ovf", {31'b0, b_ovf}, {31'b0, d[11]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_vld  = 1'b1;
        ld_byte = b;
        ld_last = last;
        step();
        ld_vld  = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic probe(input logic [31:0] addr, input logic vld,
                         input logic do_a, input probe_t ea,
                         input logic do_b, input probe_t eb);
        pc     = addr;
        pc_vld = vld;
        if (do_a) begin
            exp_qa.push_back(ea);
            stb_a = 1'b1;
        end
        if (do_b) begin
            exp_qb.push_back(eb);
            stb_b = 1'b1;
        end
        step();
        stb_a  = 1'b0;
        stb_b  = 1'b0;
        pc_vld = 1'b0;
    endtask

    task automatic probe2(input logic [31:0] addr, input logic vld, input probe_t e);
        probe(addr, vld, 1'b1, e, 1'b1, e);
    endtask

    // ---------------- directed stimulus ----------------
    logic [7:0] prog1 [8] = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h24, 8'h02, 8'h00, 8'h07};
    logic [7:0] prog2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    logic [7:0] prog3 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        rst_ = 1'b1; pc = 32'h0; pc_vld = 1'b0;
        ld_start = 1'b0; ld_byte = 8'h0; ld_vld = 1'b0; ld_last = 1'b0;
        #1;
        repeat (3) step();
        rst_ = 1'b0;
        step();

        // Reset state: IDLE serves NOP, loader not ready.
        probe2(32'h0, 1'b1, mk(32'h0, 1'b0, 11'd0, 1'b0, 1'b0));

        // Two-word program.
        exp_done_qa.push_back({1'b0, 11'd2});
        exp_done_qb.push_back({1'b0, 11'd2});
        start_load();
        probe2(32'h0, 1'b1, mk(32'h0, 1'b1, 11'd0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            send(prog1[i], i == 7);
            if (i == 3) probe2(32'h0, 1'b1, mk(32'h0, 1'b1, 11'd1, 1'b0, 1'b0));
        end
        // First RUN cycle (ld_done cycle) already serves fetches.
        probe2(32'h0, 1'b1, mk(32'h34010005, 1'b0, 11'd2, 1'b0, 1'b0));
        probe2(32'h4, 1'b1, mk(32'h24020007, 1'b0, 11'd2, 1'b0, 1'b0));
        probe2(32'h4, 1'b0, mk(32'h0, 1'b0, 11'd2, 1'b0, 1'b0));
        probe2(32'h2, 1'b1, mk(ALIGN_CHK ? 32'h0 : 32'h34010005, 1'b0, 11'd2, 1'b0, ALIGN_CHK));
        probe2(32'h7, 1'b1, mk(ALIGN_CHK ? 32'h0 : 32'h24020007, 1'b0, 11'd2, 1'b0, ALIGN_CHK));

        // Five bytes: partial last word zero-padded.
        exp_done_qa.push_back({1'b0, 11'd2});
        exp_done_qb.push_back({1'b0, 11'd2});
        start_load();
        for (int i = 0; i < 5; i++) send(prog2[i], i == 4);
        probe2(32'h4, 1'b1, mk(32'hEE000000, 1'b0, 11'd2, 1'b0, 1'b0));
        probe2(32'h0, 1'b1, mk(32'hAABBCCDD, 1'b0, 11'd2, 1'b0, 1'b0));
        probe2(32'h0010_0000, 1'b1, mk(32'h0, 1'b0, 11'd2, 1'b0, 1'b0));
        probe2(32'h0000_1000, 1'b1, mk(32'h0, 1'b0, 11'd2, 1'b0, 1'b0));
        probe(32'h10, 1'b1, 1'b0, mk(32'h0, 1'b0, 11'd0, 1'b0, 1'b0),
              1'b1, mk(32'h0, 1'b0, 11'd2, 1'b0, 1'b0));

        // Restart mid-load, coincident with a byte that must be discarded.
        exp_done_qa.push_back({1'b0, 11'd1});
        exp_done_qb.push_back({1'b0, 11'd1});
        start_load();
        for (int i = 0; i < 6; i++) send(8'(i + 1), 1'b0);
        ld_start = 1'b1; ld_vld = 1'b1; ld_byte = 8'h07;
        step();
        ld_start = 1'b0; ld_vld = 1'b0;
        probe2(32'h0, 1'b1, mk(32'h0, 1'b1, 11'd0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) send(prog3[i], i == 3);
        probe2(32'h0, 1'b1, mk(32'h11223344, 1'b0, 11'd1, 1'b0, 1'b0));
        probe2(32'h4, 1'b1, mk(32'hEE000000, 1'b0, 11'd1, 1'b0, 1'b0));

        // Twenty bytes: tiny instance fills after 16 and flags overflow.
        exp_done_qa.push_back({1'b0, 11'd5});
        exp_done_qb.push_back({1'b1, 11'd4});
        start_load();
        for (int i = 0; i < 20; i++) begin
            send(8'(8'h40 + i), i == 19);
            if (i == 15) probe2(32'h0, 1'b1, mk(32'h0, 1'b1, 11'd4, 1'b0, 1'b0));
            if (i == 16) probe(32'h0, 1'b1, 1'b1, mk(32'h0, 1'b1, 11'd4, 1'b0, 1'b0),
                               1'b1, mk(32'h0, 1'b1, 11'd4, 1'b1, 1'b0));
        end
        probe(32'h0, 1'b1, 1'b1, mk(32'h40414243, 1'b0, 11'd5, 1'b0, 1'b0),
              1'b1, mk(32'h40414243, 1'b0, 11'd4, 1'b1, 1'b0));
        probe(32'hC, 1'b1, 1'b1, mk(32'h4C4D4E4F, 1'b0, 11'd5, 1'b0, 1'b0),
              1'b1, mk(32'h4C4D4E4F, 1'b0, 11'd4, 1'b1, 1'b0));
        probe(32'h10, 1'b1, 1'b1, mk(32'h50515253, 1'b0, 11'd5, 1'b0, 1'b0),
              1'b1, mk(32'h0, 1'b0, 11'd4, 1'b1, 1'b0));
        start_load();
        probe2(32'h0, 1'b1, mk(32'h0, 1'b1, 11'd0, 1'b0, 1'b0));

        // Reset in the middle of a load takes effect without a clock edge.
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        rst_ = 1'b1;
        probe2(32'h0, 1'b1, mk(32'h0, 1'b0, 11'd0, 1'b0, 1'b0));
        rst_ = 1'b0;
        probe2(32'h0, 1'b1, mk(32'h0, 1'b0, 11'd0, 1'b0, 1'b0));

        // ld_last without ld_vld is ignored; single-byte program is padded.
        start_load();
        ld_last = 1'b1;
        probe2(32'h0, 1'b1, mk(32'h0, 1'b1, 11'd0, 1'b0, 1'b0));
        ld_last = 1'b0;
        exp_done_qa.push_back({1'b0, 11'd1});
        exp_done_qb.push_back({1'b0, 11'd1});
        send(8'h12, 1'b1);
        probe2(32'h0, 1'b1, mk(32'h12000000, 1'b0, 11'd1, 1'b0, 1'b0));

        repeat (3) step();

        // Every expected ld_done must have been seen.
        chk("a_ld_done_missing", exp_done_qa.size(), 32'd0);
        chk("b_ld_done_missing", exp_done_qb.size(), 32'd0);
        chk("a_probe_left", exp_qa.size(), 32'd0);
        chk("b_probe_left", exp_qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
